// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus blocks (init, writer, reader).
// Holds the bus timing defaults in 50 MHz clocks, the reader state encoding,
// field widths and positions, and a small constant helper.
package lcd_pkg;

   localparam int NIB_W  = 4;   // 4-bit bus mode
   localparam int BYTE_W = 8;
   localparam int BF_BIT = 7;   // busy flag position in the status byte

   // E high time shared by all bus agents
   localparam int LCD_T_E = 12;

   // Reader timing defaults
   localparam int RD_T_AS     = 3;
   localparam int RD_T_EH     = LCD_T_E;
   localparam int RD_T_GAP    = 50;
   localparam int RD_T_AH     = 2;
   localparam int RD_POLL_MAX = 100000;
   localparam int POLL_W      = 17;   // holds RD_POLL_MAX

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_SETUP,
      RD_EH1,
      RD_GAP,
      RD_EH2,
      RD_HOLD,
      RD_DONE
   } rd_state_e;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_read_ctrl_if.sv
// Request/response handshake between a bus client and lcd_read_ctrl.
//   rd_req/rd_rs/rd_poll : request, sampled while rd_ready=1
//   rd_ready             : reader idle
//   rd_valid             : one-cycle strobe qualifying rd_data/rd_timeout
// slave = the reader, master = the client.
interface lcd_read_ctrl_if;

   logic                      rd_req;
   logic                      rd_rs;
   logic                      rd_poll;
   logic                      rd_ready;
   logic                      rd_valid;
   logic [lcd_pkg::BYTE_W-1:0] rd_data;
   logic                      rd_timeout;

   modport slave (
      input  rd_req, rd_rs, rd_poll,
      output rd_ready, rd_valid, rd_data, rd_timeout
   );

   modport master (
      output rd_req, rd_rs, rd_poll,
      input  rd_ready, rd_valid, rd_data, rd_timeout
   );

endinterface

// File: rtl/lcd_nibble_strobe.sv
// One E strobe on the 4-bit LCD bus: raises E on start, holds it for T_EH
// clocks, and flags the last high cycle with done. The pad data is brought
// in through a 2-flop synchroniser; sample is the synchronised value and is
// meant to be captured by the caller while done=1.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : pulse, E rises on this edge
//   din        : raw SF_D pad value
//   e          : registered LCD_E
//   done       : last E-high cycle
//   sample     : synchronised pad nibble
module lcd_nibble_strobe
   import lcd_pkg::*;
#(
   parameter int T_EH = RD_T_EH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NIB_W-1:0] din,
   output logic             e,
   output logic             done,
   output logic [NIB_W-1:0] sample
);

   localparam int CW = (T_EH > 1) ? $clog2(T_EH) : 1;

   logic [NIB_W-1:0] sync1, sync2;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         e     <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (start) begin
            e   <= 1'b1;
            cnt <= '0;
         end else if (e) begin
            if (done) begin
               e   <= 1'b0;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign done   = e && (cnt == CW'(T_EH - 1));
   assign sample = sync2;

endmodule

// File: rtl/lcd_read_ctrl.sv
// Read side of the 4-bit character-LCD bus. Fetches one byte as two
// E-strobed nibbles (high first). RS=0 reads busy flag + address counter,
// RS=1 reads DDRAM/CGRAM data. Poll mode repeats status reads until BF=0
// or POLL_MAX reads, flagging rd_timeout in the latter case.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   rd           : client handshake (req/rs/poll in, ready/valid/data/timeout out)
//   SF_D_IN      : LCD data pads [11:8] as read back
//   LCD_E/RS/RW  : bus control, valid while bus_own=1
//   bus_own      : reader owns the bus (acceptance through end of hold)
module lcd_read_ctrl
   import lcd_pkg::*;
#(
   parameter int T_AS     = RD_T_AS,
   parameter int T_EH     = RD_T_EH,
   parameter int T_GAP    = RD_T_GAP,
   parameter int T_AH     = RD_T_AH,
   parameter int POLL_MAX = RD_POLL_MAX
)(
   input  logic             clk,
   input  logic             rst_n,
   lcd_read_ctrl_if.slave   rd,
   input  logic [NIB_W-1:0] SF_D_IN,
   output logic             LCD_E,
   output logic             LCD_RS,
   output logic             LCD_RW,
   output logic             bus_own
);

   localparam int TMAX = max_of4(T_AS, T_EH, T_GAP, T_AH);
   localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   rd_state_e         state, state_n;
   logic [CW-1:0]     cnt;
   logic              strobe_start, strobe_done;
   logic [NIB_W-1:0]  strobe_sample;
   logic              poll_q, repoll_q, bf_retry;
   logic [POLL_W-1:0] attempts;
   logic [BYTE_W-1:0] byte_q, data_q;
   logic              valid_q, timeout_q;

   // BF comes from the first nibble, already in byte_q when EH2 finishes
   assign bf_retry = poll_q && byte_q[BF_BIT] && (attempts < POLL_W'(POLL_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RD_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n      = state;
      strobe_start = 1'b0;
      case (state)
         RD_IDLE:  if (rd.rd_req) state_n = RD_SETUP;
         RD_SETUP: if (cnt == CW'(T_AS - 1)) begin
                      state_n      = RD_EH1;
                      strobe_start = 1'b1;
                   end
         RD_EH1:   if (strobe_done) state_n = RD_GAP;
         // A gap after a busy status read leads back to a fresh setup
         RD_GAP:   if (cnt == CW'(T_GAP - 1)) begin
                      if (repoll_q) begin
                         state_n = RD_SETUP;
                      end else begin
                         state_n      = RD_EH2;
                         strobe_start = 1'b1;
                      end
                   end
         RD_EH2:   if (strobe_done) state_n = bf_retry ? RD_GAP : RD_HOLD;
         RD_HOLD:  if (cnt == CW'(T_AH - 1)) state_n = RD_DONE;
         RD_DONE:  state_n = RD_IDLE;
         default:  state_n = RD_IDLE;
      endcase
   end

   // Shared phase counter for the E-low phases; restarts on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      cnt <= '0;
      else if (state_n != state)                       cnt <= '0;
      else if (state inside {RD_SETUP, RD_GAP, RD_HOLD}) cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LCD_RS    <= 1'b0;
         LCD_RW    <= 1'b0;
         bus_own   <= 1'b0;
         poll_q    <= 1'b0;
         repoll_q  <= 1'b0;
         attempts  <= '0;
         byte_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= (state_n == RD_DONE);
         if (state == RD_IDLE && rd.rd_req) begin
            LCD_RS   <= rd.rd_rs;
            LCD_RW   <= 1'b1;
            bus_own  <= 1'b1;
            poll_q   <= rd.rd_poll & ~rd.rd_rs;
            attempts <= POLL_W'(1);
         end
         if (state == RD_EH1 && strobe_done) byte_q[BYTE_W-1:NIB_W] <= strobe_sample;
         if (state == RD_EH2 && strobe_done) begin
            byte_q[NIB_W-1:0] <= strobe_sample;
            if (bf_retry) begin
               repoll_q <= 1'b1;
               attempts <= attempts + 1'b1;
            end
         end
         if (state == RD_GAP && state_n != RD_GAP) repoll_q <= 1'b0;
         // Release the bus and publish the byte together; rd_data is
         // otherwise left untouched so it holds between strobes
         if (state == RD_HOLD && state_n == RD_DONE) begin
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
            bus_own   <= 1'b0;
            data_q    <= byte_q;
            timeout_q <= poll_q & byte_q[BF_BIT];
         end
      end
   end

   lcd_nibble_strobe #(.T_EH(T_EH)) u_strobe (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (strobe_start),
      .din    (SF_D_IN),
      .e      (LCD_E),
      .done   (strobe_done),
      .sample (strobe_sample)
   );

   assign rd.rd_ready   = (state == RD_IDLE);
   assign rd.rd_valid   = valid_q;
   assign rd.rd_data    = data_q;
   assign rd.rd_timeout = timeout_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed bench for lcd_read_ctrl: a vector table of complete reads
// (single and polled) plus hand sequences for mid-read reset and a request
// held through DONE. A small LCD model presents queued nibbles on each E rise.
module tb_lcd_read_ctrl;
   import lcd_pkg::*;

   localparam int PER = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] SF_D_IN;
   logic       LCD_E, LCD_RS, LCD_RW, bus_own;

   always #(PER/2) clk = ~clk;

   lcd_read_ctrl_if rd_if ();

   lcd_read_ctrl #(.POLL_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd      (rd_if),
      .SF_D_IN (SF_D_IN),
      .LCD_E   (LCD_E),
      .LCD_RS  (LCD_RS),
      .LCD_RW  (LCD_RW),
      .bus_own (bus_own)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // LCD model and E timing capture
   logic [3:0] nibq[$];
   time        rise_t[$], fall_t[$];
   always @(posedge LCD_E) begin
      rise_t.push_back($time);
      if (nibq.size() > 0) SF_D_IN = nibq.pop_front();
   end
   always @(negedge LCD_E) fall_t.push_back($time);

   // Bus pin monitor
   logic exp_rs = 1'b0;
   int   pin_viol = 0;
   int   vcount = 0;
   always @(negedge clk) begin
      if (bus_own && (LCD_RW !== 1'b1 || LCD_RS !== exp_rs)) pin_viol++;
      if (LCD_E && !bus_own) pin_viol++;
      if (rd_if.rd_valid) vcount++;
   end

   typedef struct {
      logic        rs;
      logic        poll;
      int          n_nib;
      logic [31:0] nibs;      // consumed from the top nibble down
      logic [7:0]  exp_data;
      logic        exp_to;
      int          exp_lat;
      int          exp_pulses;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v, input logic [7:0] prev, input string tag);
      int lat, bad_w, gap;
      nibq.delete(); rise_t.delete(); fall_t.delete();
      for (int i = 0; i < v.n_nib; i++) nibq.push_back(v.nibs[31-4*i -: 4]);
      exp_rs = v.rs;
      pin_viol = 0;
      @(negedge clk);
      chk({tag, "_ready"}, rd_if.rd_ready, 1);
      rd_if.rd_req = 1'b1; rd_if.rd_rs = v.rs; rd_if.rd_poll = v.poll;
      @(posedge clk); #1;
      // inputs change after acceptance; the captured values must stick
      rd_if.rd_req = 1'b0; rd_if.rd_rs = ~v.rs; rd_if.rd_poll = ~v.poll;
      chk({tag, "_accept"}, {bus_own, LCD_RW, LCD_RS, rd_if.rd_ready}, {1'b1, 1'b1, v.rs, 1'b0});
      lat = 0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (k == 40) chk({tag, "_data_hold"}, rd_if.rd_data, prev);
         if (rd_if.rd_valid) begin lat = k; break; end
      end
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_data"}, rd_if.rd_data, v.exp_data);
      chk({tag, "_timeout"}, rd_if.rd_timeout, v.exp_to);
      @(negedge clk);
      chk({tag, "_idle"}, {rd_if.rd_valid, bus_own, LCD_RW, LCD_RS, LCD_E, rd_if.rd_ready}, 6'b000001);
      chk({tag, "_pulses"}, rise_t.size(), v.exp_pulses);
      bad_w = 0;
      for (int i = 0; i < fall_t.size(); i++)
         if (i >= rise_t.size() || (fall_t[i] - rise_t[i]) != time'(PER * RD_T_EH)) bad_w++;
      chk({tag, "_widths"}, bad_w, 0);
      gap = (rise_t.size() > 1 && fall_t.size() > 0) ? int'((rise_t[1] - fall_t[0]) / PER) : -1;
      chk({tag, "_gap"}, gap, RD_T_GAP);
      chk({tag, "_pins"}, pin_viol, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, extra, vc0;
      logic e_before;
      logic [7:0] prev;

      rd_if.rd_req = 1'b0; rd_if.rd_rs = 1'b0; rd_if.rd_poll = 1'b0;
      SF_D_IN = 4'h0;

      //        rs    poll  n  nibbles        data   to    lat  pulses
      vecs[0] = '{1'b0, 1'b0, 2, 32'h2500_0000, 8'h25, 1'b0, 80,  2};
      vecs[1] = '{1'b1, 1'b0, 2, 32'hA700_0000, 8'hA7, 1'b0, 80,  2};
      vecs[2] = '{1'b0, 1'b1, 2, 32'h0A00_0000, 8'h0A, 1'b0, 80,  2};
      vecs[3] = '{1'b1, 1'b1, 2, 32'hC300_0000, 8'hC3, 1'b0, 80,  2};  // poll ignored for data
      vecs[4] = '{1'b0, 1'b0, 2, 32'hF000_0000, 8'hF0, 1'b0, 80,  2};  // BF=1, no poll
      vecs[5] = '{1'b0, 1'b1, 8, 32'h8091_8203, 8'h03, 1'b0, 461, 8};  // 3 busy then ready
      vecs[6] = '{1'b0, 1'b1, 8, 32'h8192_8384, 8'h84, 1'b1, 461, 8};  // stuck busy, 4 reads

      #2 rst_n = 1'b0;
      #20;
      chk("reset_state",
          {rd_if.rd_ready, rd_if.rd_valid, rd_if.rd_timeout, bus_own, LCD_E, LCD_RS, LCD_RW}, 7'b1000000);
      chk("reset_data", rd_if.rd_data, 0);
      @(negedge clk) rst_n = 1'b1;

      prev = 8'h00;
      foreach (vecs[i]) begin
         run_vec(vecs[i], prev, $sformatf("vec%0d", i));
         prev = vecs[i].exp_data;
      end

      // Reset in the middle of EH2
      nibq.delete(); rise_t.delete(); fall_t.delete();
      nibq.push_back(4'h2); nibq.push_back(4'h5);
      exp_rs = 1'b0;
      @(negedge clk);
      rd_if.rd_req = 1'b1; rd_if.rd_rs = 1'b0; rd_if.rd_poll = 1'b0;
      @(posedge clk); #1 rd_if.rd_req = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rise_t.size() >= 2) break;
      end
      @(negedge clk);
      e_before = LCD_E;
      chk("rst_in_eh2", e_before, 1);
      vc0 = vcount;
      rst_n = 1'b0;
      #1;
      chk("rst_async", {LCD_E, LCD_RW, LCD_RS, bus_own, rd_if.rd_valid, rd_if.rd_ready}, 6'b000001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_no_valid", vcount - vc0, 0);
      run_vec(vecs[0], 8'h00, "post_rst");

      // rd_req held through DONE: one new acceptance on the first IDLE cycle
      nibq.delete(); rise_t.delete(); fall_t.delete();
      nibq.push_back(4'h6); nibq.push_back(4'h1); nibq.push_back(4'h7); nibq.push_back(4'h2);
      exp_rs = 1'b1; pin_viol = 0;
      @(negedge clk);
      rd_if.rd_req = 1'b1; rd_if.rd_rs = 1'b1; rd_if.rd_poll = 1'b0;
      @(posedge clk); #1;
      chk("held_accept1", bus_own, 1);
      extra = 0; lat = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (rd_if.rd_ready && rd_if.rd_req) extra++;
         if (rd_if.rd_valid) begin lat = k; break; end
      end
      chk("held_latency1", lat, 80);
      chk("held_data1", rd_if.rd_data, 8'h61);
      chk("held_done_ready", rd_if.rd_ready, 0);
      @(negedge clk);
      chk("held_idle_ready", rd_if.rd_ready, 1);
      @(posedge clk); #1;
      rd_if.rd_req = 1'b0;
      chk("held_accept2", bus_own, 1);
      lat = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (rd_if.rd_ready && rd_if.rd_req) extra++;
         if (rd_if.rd_valid) begin lat = k; break; end
      end
      chk("held_latency2", lat, 80);
      chk("held_data2", rd_if.rd_data, 8'h72);
      chk("held_extra_accepts", extra, 0);
      chk("held_pins", pin_viol, 0);
      repeat (5) @(negedge clk);
      chk("held_quiet", {bus_own, LCD_E, rd_if.rd_ready}, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
